// File: rtl/ate_pkg.sv
// Shared constants and scan-state encoding for the adaptive threshold engine pixel path.
package ate_pkg;
  localparam int BLK_DIM = 8;
  localparam int BLK_PIX = 64;
  localparam int NBLK_S  = 6;
  localparam int NBLK_L  = 66;
  localparam int ADDR_W  = 13;
  localparam int FIFO_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;
endpackage

// File: rtl/ate_skid_fifo.sv
// Two-entry output buffer for returned pixels; entry = {frame_start, block_start, pixel}.
module ate_skid_fifo (
  input  logic              clk,
  input  logic              CAL_reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [9:0]        i_din,
  output logic [9:0]        o_dout,
  output logic [1:0]        o_count
);
  import ate_pkg::*;

  logic [FIFO_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  // The caller never pushes when full nor pops when empty.
  always_ff @(posedge clk or negedge CAL_reset) begin
    if (!CAL_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/ate_pix_scan.sv
// Streams a row-major 8-row strip from pixel memory as consecutive 8x8 blocks.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing reads, c fastest then r then b
//   DRAIN | last address issued, emptying pipeline
//   DONE  | one-cycle done pulse
module ate_pix_scan #(
  parameter int NBLK_S = ate_pkg::NBLK_S,
  parameter int NBLK_L = ate_pkg::NBLK_L,
  parameter int ADDR_W = ate_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              CAL_reset,
  input  logic              i_start,
  input  logic              i_type_in,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_pix_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic              o_type,
  output logic              o_frame_start,
  output logic              o_block_start,
  output logic              o_busy,
  output logic              o_done
);
  import ate_pkg::*;

  localparam int BLK_W = $clog2(NBLK_L + 1);

  scan_state_t       r_state, w_next;
  logic              r_type;
  logic [2:0]        r_col, r_row;
  logic [BLK_W-1:0]  r_blk;
  logic [ADDR_W-1:0] r_addr, r_row_base, r_blk_base;
  logic              r_rd_d;
  logic [1:0]        r_tag_d;
  logic [1:0]        w_cnt;
  logic [9:0]        w_head;
  logic              w_pop, w_issue, w_row_end, w_blk_end, w_last_addr, w_valid;
  logic [2:0]        w_occ;
  logic [BLK_W-1:0]  w_blk_last;
  logic [ADDR_W-1:0] w_stride;

  // Occupancy after this cycle's pop, counting the read whose data lands this cycle.
  assign w_valid     = (w_cnt != 2'd0);
  assign w_pop       = w_valid && i_pix_ready;
  assign w_occ       = {1'b0, w_cnt} + {2'b0, r_rd_d} - {2'b0, w_pop};
  assign w_issue     = (r_state == RUN) && (w_occ < 3'd2);
  assign w_row_end   = (r_col == 3'(BLK_DIM - 1));
  assign w_blk_end   = w_row_end && (r_row == 3'(BLK_DIM - 1));
  assign w_blk_last  = r_type ? BLK_W'(NBLK_L - 1) : BLK_W'(NBLK_S - 1);
  assign w_last_addr = w_blk_end && (r_blk == w_blk_last);
  assign w_stride    = r_type ? ADDR_W'(BLK_DIM * NBLK_L) : ADDR_W'(BLK_DIM * NBLK_S);

  always_ff @(posedge clk or negedge CAL_reset) begin
    if (!CAL_reset) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (w_issue && w_last_addr) w_next = DRAIN;
      DRAIN:   if (w_pop && (w_occ == 3'd0)) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_mem_rd = w_issue;
    o_busy   = (r_state == RUN) || (r_state == DRAIN);
    o_done   = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge CAL_reset) begin
    if (!CAL_reset) begin
      r_type     <= 1'b0;
      r_col      <= 3'd0;
      r_row      <= 3'd0;
      r_blk      <= '0;
      r_addr     <= '0;
      r_row_base <= '0;
      r_blk_base <= '0;
    end else if ((r_state == IDLE) && i_start) begin
      r_type     <= i_type_in;
      r_col      <= 3'd0;
      r_row      <= 3'd0;
      r_blk      <= '0;
      r_addr     <= '0;
      r_row_base <= '0;
      r_blk_base <= '0;
    end else if (w_issue) begin
      if (!w_row_end) begin
        r_col  <= r_col + 3'd1;
        r_addr <= r_addr + ADDR_W'(1);
      end else if (!w_blk_end) begin
        r_col      <= 3'd0;
        r_row      <= r_row + 3'd1;
        r_row_base <= r_row_base + w_stride;
        r_addr     <= r_row_base + w_stride + r_blk_base;
      end else begin
        r_col      <= 3'd0;
        r_row      <= 3'd0;
        r_blk      <= r_blk + BLK_W'(1);
        r_row_base <= '0;
        r_blk_base <= r_blk_base + ADDR_W'(BLK_DIM);
        r_addr     <= r_blk_base + ADDR_W'(BLK_DIM);
      end
    end
  end

  // Markers ride alongside the read so they stay attached to their pixel.
  always_ff @(posedge clk or negedge CAL_reset) begin
    if (!CAL_reset) begin
      r_rd_d  <= 1'b0;
      r_tag_d <= 2'b00;
    end else begin
      r_rd_d  <= w_issue;
      r_tag_d <= {(r_blk == '0) && (r_row == 3'd0) && (r_col == 3'd0),
                  (r_row == 3'd0) && (r_col == 3'd0)};
    end
  end

  ate_skid_fifo u_fifo (
    .clk      (clk),
    .CAL_reset(CAL_reset),
    .i_push   (r_rd_d),
    .i_pop    (w_pop),
    .i_din    ({r_tag_d, i_mem_data}),
    .o_dout   (w_head),
    .o_count  (w_cnt)
  );

  assign o_mem_addr    = r_addr;
  assign o_type        = r_type;
  assign o_pix_valid   = w_valid;
  assign o_pix_data    = w_head[7:0];
  assign o_frame_start = w_valid && w_head[9];
  assign o_block_start = w_valid && w_head[8];
endmodule

// File: tb/tb_ate_pix_scan.sv
// Directed bench for ate_pix_scan: memory returns mem[a] = a[7:0], a monitor models the expected stream.
module tb_ate_pix_scan;
  import ate_pkg::*;

  logic              clk = 1'b0;
  logic              CAL_reset;
  logic              i_start, i_type_in, i_pix_ready;
  logic [7:0]        i_mem_data;
  logic              o_mem_rd, o_pix_valid, o_type, o_frame_start, o_block_start, o_busy, o_done;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_pix_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // monitor state (written only by the monitor)
  int xfers = 0, bs_cnt = 0, fs_cnt = 0, seq_err = 0, occ_err = 0, done_cnt = 0, done_cyc = 0;
  int q = 0, mk = 0, mnb = 0, maddr = 0;
  logic [9:0] pix_log [0:4223];

  // stimulus-side bookkeeping (written only by the stimulus block)
  int base_x = 0;
  logic exp_type = 1'b0;
  int b_bs, b_fs, b_seq, b_occ, b_done, p_cyc;

  ate_pix_scan dut (
    .clk          (clk),
    .CAL_reset    (CAL_reset),
    .i_start      (i_start),
    .i_type_in    (i_type_in),
    .o_mem_rd     (o_mem_rd),
    .o_mem_addr   (o_mem_addr),
    .i_mem_data   (i_mem_data),
    .o_pix_data   (o_pix_data),
    .o_pix_valid  (o_pix_valid),
    .i_pix_ready  (i_pix_ready),
    .o_type       (o_type),
    .o_frame_start(o_frame_start),
    .o_block_start(o_block_start),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk) i_mem_data <= o_mem_rd ? o_mem_addr[7:0] : 8'hEE;

  always @(negedge clk) begin
    if (!CAL_reset) begin
      q = 0;
    end else begin
      if (o_pix_valid && i_pix_ready) begin
        mk    = xfers - base_x;
        mnb   = exp_type ? NBLK_L : NBLK_S;
        maddr = ((mk % BLK_PIX) / BLK_DIM) * BLK_DIM * mnb + BLK_DIM * (mk / BLK_PIX) + (mk % BLK_DIM);
        if (mk < 4224) pix_log[mk] = {o_frame_start, o_block_start, o_pix_data};
        if (o_pix_data !== maddr[7:0] || o_block_start !== (mk % BLK_PIX == 0) ||
            o_frame_start !== (mk == 0))
          seq_err++;
        xfers++;
        if (o_block_start) bs_cnt++;
        if (o_frame_start) fs_cnt++;
      end
      q = q + int'(o_mem_rd) - int'(o_pix_valid && i_pix_ready);
      if (q > 2) occ_err++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({o_mem_rd, o_mem_addr, o_pix_data, o_pix_valid, o_type,
                o_frame_start, o_block_start, o_busy, o_done});
  endfunction

  task automatic start_frame(input logic t);
    @(posedge clk);
    #1;
    i_start   = 1'b1;
    i_type_in = t;
    exp_type  = t;
    base_x    = xfers;
    b_bs      = bs_cnt;
    b_fs      = fs_cnt;
    b_seq     = seq_err;
    b_occ     = occ_err;
    b_done    = done_cnt;
    @(posedge clk);
    #1;
    p_cyc     = cyc;
    i_start   = 1'b0;
    i_type_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == b_done && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 32'(done_cnt - b_done), 32'd1);
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while ((xfers - base_x) != target && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_pixel", 32'(xfers - base_x), 32'(target));
  endtask

  initial begin
    logic [7:0] held;
    int unstable, n;
    CAL_reset   = 1'b0;
    i_start     = 1'b0;
    i_type_in   = 1'b0;
    i_pix_ready = 1'b1;
    #12;
    chk("reset_outputs", all_out(), 32'd0);
    @(negedge clk);
    CAL_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_outputs", all_out(), 32'd0);

    // Type 0, ready held high
    start_frame(1'b0);
    @(negedge clk);
    chk("t0_busy_T1", 32'(o_busy), 32'd1);
    chk("t0_rd_T1", 32'(o_mem_rd), 32'd1);
    chk("t0_addr_T1", 32'(o_mem_addr), 32'd0);
    wait_done(600, "t0_done");
    chk("t0_done_cycle", 32'(done_cyc - p_cyc), 32'(2 + 384));
    @(negedge clk);
    chk("t0_xfers", 32'(xfers - base_x), 32'd384);
    chk("t0_block_starts", 32'(bs_cnt - b_bs), 32'd6);
    chk("t0_frame_starts", 32'(fs_cnt - b_fs), 32'd1);
    chk("t0_sequence", 32'(seq_err - b_seq), 32'd0);
    chk("t0_pix0", 32'(pix_log[0]), 32'h300);
    chk("t0_pix7", 32'(pix_log[7]), 32'd7);
    chk("t0_pix8", 32'(pix_log[8]), 32'd48);
    chk("t0_pix9", 32'(pix_log[9]), 32'd49);
    chk("t0_pix64", 32'(pix_log[64]), 32'h108);
    repeat (4) @(negedge clk);
    chk("t0_busy_after", 32'(o_busy), 32'd0);
    chk("t0_done_single", 32'(done_cnt - b_done), 32'd1);

    // Type 1, ready held high
    start_frame(1'b1);
    @(negedge clk);
    chk("t1_type", 32'(o_type), 32'd1);
    wait_done(5000, "t1_done");
    chk("t1_done_cycle", 32'(done_cyc - p_cyc), 32'(2 + 4224));
    chk("t1_xfers", 32'(xfers - base_x), 32'd4224);
    chk("t1_block_starts", 32'(bs_cnt - b_bs), 32'd66);
    chk("t1_sequence", 32'(seq_err - b_seq), 32'd0);
    chk("t1_last_pix", 32'(pix_log[4223][7:0]), 32'h7F);

    // Type 0, random ready
    start_frame(1'b0);
    n = 0;
    while (done_cnt == b_done && n < 3000) begin
      @(posedge clk);
      #1;
      i_pix_ready = 1'($urandom_range(0, 1));
      n++;
    end
    i_pix_ready = 1'b1;
    chk("rnd_done", 32'(done_cnt - b_done), 32'd1);
    chk("rnd_xfers", 32'(xfers - base_x), 32'd384);
    chk("rnd_sequence", 32'(seq_err - b_seq), 32'd0);
    chk("rnd_outstanding", 32'(occ_err - b_occ), 32'd0);

    // Stall for 20 cycles with pixel 63 at the head
    start_frame(1'b0);
    wait_xfers(63);
    i_pix_ready = 1'b0;
    @(negedge clk);
    held = o_pix_data;
    unstable = (o_pix_valid && !o_block_start) ? 0 : 1;
    repeat (19) begin
      @(negedge clk);
      if (o_pix_data !== held || !o_pix_valid || o_block_start) unstable++;
    end
    @(posedge clk);
    #1;
    i_pix_ready = 1'b1;
    chk("stall_pix63", 32'(held), 32'd87);
    chk("stall_stable", 32'(unstable), 32'd0);
    wait_done(700, "stall_done");
    chk("stall_xfers", 32'(xfers - base_x), 32'd384);
    chk("stall_block_starts", 32'(bs_cnt - b_bs), 32'd6);
    chk("stall_sequence", 32'(seq_err - b_seq), 32'd0);

    // start with type_in=1 mid-frame is ignored
    start_frame(1'b0);
    repeat (50) @(posedge clk);
    #1;
    i_start   = 1'b1;
    i_type_in = 1'b1;
    @(posedge clk);
    #1;
    i_start   = 1'b0;
    i_type_in = 1'b0;
    @(negedge clk);
    chk("mid_type", 32'(o_type), 32'd0);
    wait_done(600, "mid_done");
    chk("mid_xfers", 32'(xfers - base_x), 32'd384);
    chk("mid_sequence", 32'(seq_err - b_seq), 32'd0);
    repeat (10) @(negedge clk);
    chk("mid_no_restart", 32'(o_busy), 32'd0);
    chk("mid_done_single", 32'(done_cnt - b_done), 32'd1);

    // Abort at pixel 100 then restart
    start_frame(1'b0);
    wait_xfers(100);
    #1;
    CAL_reset = 1'b0;
    #1;
    chk("abort_outputs", all_out(), 32'd0);
    repeat (3) @(negedge clk);
    CAL_reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - b_done), 32'd0);
    chk("abort_idle", 32'(o_busy), 32'd0);
    start_frame(1'b0);
    @(negedge clk);
    chk("restart_rd", 32'(o_mem_rd), 32'd1);
    chk("restart_addr", 32'(o_mem_addr), 32'd0);
    wait_done(600, "restart_done");
    chk("restart_xfers", 32'(xfers - base_x), 32'd384);
    chk("restart_sequence", 32'(seq_err - b_seq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
